// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq : multi-cycle iterative integer divider for the ALU DIV/DIVU path.
//
// Restoring shift-subtract on operand magnitudes, one quotient bit per cycle,
// followed by a single sign-adjust cycle and a one-cycle Done pulse.
//   Q = quotient (LO), R = remainder (HI), Z = (Q == 0), V = INT_MIN / -1.
//
// Optional build macro: DIV_ZERO_FLAG_EN
//   defined   : adds output DZ; a zero divisor skips the CALC phase
//               (IDLE -> ADJ -> DONE) and sets DZ with the other results.
//   undefined : no DZ port; a zero divisor runs the full iteration count.
// Divide by zero always yields Q = all ones, R = dividend.
//
// Handshake: Start is sampled only while idle (Busy == 0). Once accepted,
// Busy stays high until and including the Done cycle; Start while Busy is
// dropped, never queued. Results are valid from the Done cycle on and hold
// until the next operation reaches its adjust cycle.
//
// o_dbg_state exposes the FSM state encoding for checkers.
// -----------------------------------------------------------------------------
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic             Sign,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             Z,
   output logic             V,
`ifdef DIV_ZERO_FLAG_EN
   output logic             DZ,
`endif
   output logic [1:0]       o_dbg_state
);

   // Counter width: enough bits to count 0..WIDTH-1.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_ADJ  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;         // original dividend, returned as R on B == 0
   logic             r_b_zero;    // captured divisor was zero
   logic [WIDTH-1:0] r_div_mag;   // |B|
   logic [WIDTH-1:0] r_rem;       // partial remainder (magnitude)
   logic [WIDTH-1:0] r_quo;       // dividend shifting out / quotient shifting in
   logic             r_neg_q;     // quotient must be negated in ADJ
   logic             r_neg_r;     // remainder must be negated in ADJ
   logic             r_ovf;       // INT_MIN / -1 detected at capture

   // Registered results
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic             r_z;
   logic             r_v;
`ifdef DIV_ZERO_FLAG_EN
   logic             r_dz;
`endif

   // ---------------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic             w_b_zero;
   logic             w_ovf;
   logic             w_neg_q;
   logic             w_neg_r;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;
   logic             w_trial_neg;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;
   logic [WIDTH-1:0] w_q_fin;
   logic [WIDTH-1:0] w_r_fin;

   // Operand magnitudes and sign decisions, evaluated on the raw inputs so
   // they can be captured in the same cycle Start is accepted.  |INT_MIN|
   // wraps to INT_MIN itself, which is exactly 2^(WIDTH-1) read as unsigned.
   always_comb begin
      w_a_mag  = (Sign && A[WIDTH-1]) ? (~A + 1'b1) : A;
      w_b_mag  = (Sign && B[WIDTH-1]) ? (~B + 1'b1) : B;
      w_b_zero = (B == '0);
      w_neg_q  = Sign && (A[WIDTH-1] != B[WIDTH-1]);
      w_neg_r  = Sign && A[WIDTH-1];
      w_ovf    = Sign && (A == INT_MIN) && (B == '1);
   end

   // One restoring step: shift the next dividend bit into the remainder,
   // try subtracting the divisor, keep the difference only if non-negative.
   always_comb begin
      w_shift     = {r_rem, r_quo[WIDTH-1]};
      w_trial     = w_shift - {1'b0, r_div_mag};
      w_trial_neg = w_trial[WIDTH];
      w_rem_nxt   = w_trial_neg ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
      w_quo_nxt   = {r_quo[WIDTH-2:0], ~w_trial_neg};
   end

   // Final sign adjustment; a zero divisor overrides the iterative result.
   // INT_MIN / -1 needs no special case: the magnitude quotient is 2^(WIDTH-1)
   // with equal operand signs, which already reads back as INT_MIN.
   always_comb begin
      if (r_b_zero) begin
         w_q_fin = '1;
         w_r_fin = r_a;
      end else begin
         w_q_fin = r_neg_q ? (~r_quo + 1'b1) : r_quo;
         w_r_fin = r_neg_r ? (~r_rem + 1'b1) : r_rem;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM with datapath and result registers; reset dominates everything.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_a       <= '0;
         r_b_zero  <= 1'b0;
         r_div_mag <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_ovf     <= 1'b0;
         r_q       <= '0;
         r_r       <= '0;
         r_z       <= 1'b0;
         r_v       <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
         r_dz      <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  r_a       <= A;
                  r_b_zero  <= w_b_zero;
                  r_div_mag <= w_b_mag;
                  r_rem     <= '0;
                  r_quo     <= w_a_mag;
                  r_neg_q   <= w_neg_q;
                  r_neg_r   <= w_neg_r;
                  r_ovf     <= w_ovf;
                  r_cnt     <= '0;
`ifdef DIV_ZERO_FLAG_EN
                  r_state   <= w_b_zero ? S_ADJ : S_CALC;
`else
                  r_state   <= S_CALC;
`endif
               end
            end

            S_CALC: begin
               r_rem <= w_rem_nxt;
               r_quo <= w_quo_nxt;
               if (r_cnt == CNT_LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_ADJ;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
               end
            end

            S_ADJ: begin
               r_q     <= w_q_fin;
               r_r     <= w_r_fin;
               r_z     <= (w_q_fin == '0);
               r_v     <= r_ovf;
`ifdef DIV_ZERO_FLAG_EN
               r_dz    <= r_b_zero;
`endif
               r_state <= S_DONE;
            end

            S_DONE: begin
               // Start is deliberately not looked at here.
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: straight decodes of registered state and result registers.
   // ---------------------------------------------------------------------------
   assign Busy        = (r_state != S_IDLE);
   assign Done        = (r_state == S_DONE);
   assign Q           = r_q;
   assign R           = r_r;
   assign Z           = r_z;
   assign V           = r_v;
`ifdef DIV_ZERO_FLAG_EN
   assign DZ          = r_dz;
`endif
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq : directed-vector bench for div_seq (WIDTH = 32).
// The stimulus process pushes each expected result and its expected Done
// cycle; an independent monitor pops and compares on every Done pulse.
// Build with +define+DIV_ZERO_FLAG_EN to exercise the DZ variant.
// -----------------------------------------------------------------------------
module tb_div_seq;

   localparam int W     = 32;
   localparam int EXP_W = 2 * W + 3;   // {dz, q, r, z, v}
   localparam int LAT   = W + 2;
`ifdef DIV_ZERO_FLAG_EN
   localparam int   LAT_Z = 2;
   localparam logic DZ_E  = 1'b1;
`else
   localparam int   LAT_Z = W + 2;
   localparam logic DZ_E  = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         Start = 1'b0;
   logic         Sign = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         Busy;
   logic         Done;
   logic [W-1:0] Q;
   logic [W-1:0] R;
   logic         Z;
   logic         V;
   logic [1:0]   dbg_state;
`ifdef DIV_ZERO_FLAG_EN
   logic         DZ;
`endif

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   div_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .Start       (Start),
      .Sign        (Sign),
      .A           (A),
      .B           (B),
      .Busy        (Busy),
      .Done        (Done),
      .Q           (Q),
      .R           (R),
      .Z           (Z),
      .V           (V),
`ifdef DIV_ZERO_FLAG_EN
      .DZ          (DZ),
`endif
      .o_dbg_state (dbg_state)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   logic [EXP_W-1:0] exp_q[$];
   int               cyc_q[$];
   int               n_checks = 0;
   int               n_fail   = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every Done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      int               ec;
      if (!reset && Done) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got Done=1 expected no Done (t=%0t)", $time);
         end else begin
            e  = exp_q.pop_front();
            ec = cyc_q.pop_front();
            chk("done_cycle", W'(cyc), W'(ec));
            chk("Q", Q, e[2*W+1:W+2]);
            chk("R", R, e[W+1:2]);
            chk("Z", W'(Z), W'(e[1]));
            chk("V", W'(V), W'(e[0]));
`ifdef DIV_ZERO_FLAG_EN
            chk("DZ", W'(DZ), W'(e[2*W+2]));
`endif
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic ez, input logic ev, input logic edz, input int lat);
      @(negedge clk);
      Sign  = s;
      A     = a;
      B     = b;
      Start = 1'b1;
      exp_q.push_back({edz, eq, er, ez, ev});
      cyc_q.push_back(cyc + lat);
      @(negedge clk);
      Start = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((exp_q.size() != 0 || Busy) && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: got no Done within 200 cycles expected Done");
         exp_q.delete();
         cyc_q.delete();
      end
   endtask

   task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ez, input logic ev, input logic edz, input int lat);
      start_op(s, a, b, eq, er, ez, ev, edz, lat);
      wait_idle();
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int c0;
      int busy_cnt;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", W'(Busy), '0);
      chk("rst_done", W'(Done), '0);
      chk("rst_Q", Q, '0);
      chk("rst_R", R, '0);
      chk("rst_Z", W'(Z), '0);
      chk("rst_V", W'(V), '0);
      chk("rst_state", W'(dbg_state), '0);
`ifdef DIV_ZERO_FLAG_EN
      chk("rst_DZ", W'(DZ), '0);
`endif

      // Unsigned basic with Busy window: Busy high for exactly 34 cycles.
      start_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, LAT);
      busy_cnt = 0;
      for (int k = 1; k <= LAT; k++) begin
         if (Busy) busy_cnt++;
         @(negedge clk);
      end
      chk("busy_cycles", W'(busy_cnt), W'(LAT));
      chk("busy_after", W'(Busy), '0);
      wait_idle();

      // Signed truncation toward zero
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, LAT);
      run_op(1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0, 1'b0, 1'b0, LAT);
      run_op(1'b1, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, LAT);
      run_op(1'b1, 32'd0,         32'd5,        32'd0,         32'd0,        1'b1, 1'b0, 1'b0, LAT);

      // Overflow and the same operands unsigned
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0, 1'b1, 1'b0, LAT);
      run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b1, 1'b0, 1'b0, LAT);
      run_op(1'b0, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0, 1'b0, 1'b0, LAT);

      // Divide by zero, both modes
      run_op(1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b0, 1'b0, DZ_E, LAT_Z);
      run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 1'b0, DZ_E, LAT_Z);

      // Handshake: Start at t+5 and t+34 ignored, Start at t+35 accepted.
      start_op(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0, 1'b0, LAT);
      c0 = cyc - 1;
      while (cyc < c0 + 5) @(negedge clk);
      Start = 1'b1; Sign = 1'b1; A = 32'd5; B = 32'd5;
      @(negedge clk);
      Start = 1'b0;
      while (cyc < c0 + LAT) @(negedge clk);
      Start = 1'b1; Sign = 1'b0; A = 32'd77; B = 32'd7;
      @(negedge clk);
      A = 32'd50; B = 32'd8;
      exp_q.push_back({1'b0, 32'd6, 32'd2, 1'b0, 1'b0});
      cyc_q.push_back(cyc + LAT);
      @(negedge clk);
      Start = 1'b0;
      wait_idle();

      // Reset mid-operation: aborted, results cleared, no Done afterwards.
      @(negedge clk);
      c0 = cyc;
      Start = 1'b1; Sign = 1'b0; A = 32'h0000_DEAD; B = 32'd3;
      @(negedge clk);
      Start = 1'b0;
      while (cyc < c0 + 10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_busy", W'(Busy), '0);
      chk("midrst_Q", Q, '0);
      chk("midrst_R", R, '0);
      repeat (40) @(negedge clk);
      chk("midrst_idle", W'(Busy), '0);
      run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, LAT);

      chk("queue_empty", W'(exp_q.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle iterative 32-bit integer divider for the ALU's DIV/DIVU path; the inverse counterpart of the combinational adder/multiplier datapath.
- Accepts dividend/divisor with a Sign select and produces quotient (LO) and remainder (HI) after a fixed latency.
- Reports zero and overflow flags in the same style as the adder.
- Sits beside the ALU; the pipeline stalls on Busy.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Start  input  1  request; sampled only in IDLE
- Sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with Start
- A  input  WIDTH  dividend, captured with Start
- B  input  WIDTH  divisor, captured with Start
- Busy  output  1  high whenever state != IDLE
- Done  output  1  one-cycle pulse, results valid
- Q  output  WIDTH  quotient (LO)
- R  output  WIDTH  remainder (HI)
- Z  output  1  Q == 0
- V  output  1  signed overflow (INT_MIN / -1)

Behaviour:
- Reset (synchronous, active-high, dominates everything): state=IDLE, Busy=0, Done=0, Q=0, R=0, Z=0, V=0, iteration counter=0. Reset mid-operation aborts the operation; no Done is produced.
- States:
  - IDLE: Start=1 captures A, B and Sign, then goes to CALC.
  - CALC: WIDTH cycles of restoring shift-subtract on magnitudes, counter 0..WIDTH-1; at counter WIDTH-1 goes to ADJ.
  - ADJ: one cycle; applies signs and writes Q, R, Z, V.
  - DONE: Done=1 for this cycle only, then IDLE.
- Latency: Start high in IDLE at cycle t -> CALC cycles t+1..t+WIDTH, ADJ at t+WIDTH+1, Done=1 at t+WIDTH+2 (t+34 for WIDTH=32). Busy=1 from t+1 through t+WIDTH+2.
- Start while Busy is ignored; no queueing. Start in the DONE cycle is also ignored; the earliest accepted Start is the cycle after Done.
- Q, R, Z and V are registered. They update only in ADJ, hold until the next ADJ, and stay stable after Done.
- Unsigned: Q = A/B, R = A mod B.
- Signed:
  - Divide |A| by |B| as unsigned (|INT_MIN| = 2^(WIDTH-1), treated as unsigned).
  - Q is negated if A[MSB] != B[MSB]; R takes the sign of A. Q truncates toward zero.
  - INT_MIN / -1: Q = INT_MIN (0x80000000), R = 0, V = 1.
  - V = 0 in every other case, and always 0 when Sign = 0.
- Divide by zero (B=0), either mode: Q = all ones, R = A, V = 0, Z = 0. Default latency is unchanged.
- Z = 1 iff the final Q is 0.

Optional Feature:
- Macro: DIV_ZERO_FLAG_EN.
- Defined:
  - Adds output DZ (1 bit, reset 0).
  - When captured B == 0, skips CALC: IDLE -> ADJ -> DONE, so Done arrives at t+2.
  - Q = all ones, R = A, DZ = 1, registered with the other results. DZ = 0 for any nonzero divisor.
- Undefined: no DZ port; B == 0 takes the full WIDTH+2 latency with the same Q/R values.

Test Plan:
- Unsigned basic: Sign=0, A=100, B=7, Start 1 cycle -> Done exactly 34 cycles later, Q=14, R=2, Z=0, V=0; Busy high for cycles 1..34.
- Signed rounding: Sign=1, A=-7 (0xFFFFFFF9), B=2 -> Q=-3 (0xFFFFFFFD), R=-1 (0xFFFFFFFF). Repeat with A=7, B=-2 -> Q=-3, R=1.
- Overflow and unsigned large: Sign=1, A=0x80000000, B=0xFFFFFFFF -> Q=0x80000000, R=0, V=1. Same operands with Sign=0 -> Q=0, R=0x80000000, Z=1, V=0.
- Divide by zero: A=0x1234, B=0 -> Q=0xFFFFFFFF, R=0x1234. Done at t+34 without the macro; Done at t+2 with DZ=1 when DIV_ZERO_FLAG_EN is defined.
- Handshake: pulse Start again at cycles t+5 and t+34 with other operands -> both ignored, results from the first op only. Start at t+35 -> accepted.
- Reset mid-op: assert reset at t+10 for 1 cycle -> next cycle Busy=0, Q=R=0, no Done pulse. A new Start afterwards completes normally.
